// File: rtl/uart_receiver.sv
// 8N1 UART receive path: two-flop input synchronizer, mid-bit sampling FSM and a
// single-entry holding register with valid/ready handoff and error pulses.
module uart_receiver #(
    parameter int CLKFREQ  = 100_000_000,
    parameter int BAUDRATE = 115200
) (
    input  logic       sclk,
    input  logic       rstn,
    input  logic       uartRx,
    output logic [7:0] outByte,
    output logic       dataValid,
    input  logic       dataReady,
    output logic       framingErr,
    output logic       overrun,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLKFREQ / BAUDRATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t           state_r;
    logic             rxS1_r;
    logic             rxS_r;
    logic [CNT_W-1:0] bitCnt_r;
    logic [2:0]       bitIdx_r;
    logic [7:0]       shiftReg_r;
    logic             commitPend_r;
    logic [7:0]       outByte_r;
    logic             dataValid_r;
    logic             framingErr_r;
    logic             overrun_r;
    logic             busy_r;

    assign outByte    = outByte_r;
    assign dataValid  = dataValid_r;
    assign framingErr = framingErr_r;
    assign overrun    = overrun_r;
    assign busy       = busy_r;

    // Two-flop synchronizer for the asynchronous RX line, reset to the idle level.
    always_ff @(posedge sclk) begin
        if (!rstn) begin
            rxS1_r <= 1'b1;
            rxS_r  <= 1'b1;
        end else begin
            rxS1_r <= uartRx;
            rxS_r  <= rxS1_r;
        end
    end

    // Frame recovery FSM; a line returning high during the first half of the
    // start bit is treated as a glitch and drops straight back to IDLE.
    always_ff @(posedge sclk) begin
        if (!rstn) begin
            state_r      <= IDLE;
            bitCnt_r     <= '0;
            bitIdx_r     <= 3'd0;
            shiftReg_r   <= 8'h00;
            commitPend_r <= 1'b0;
            framingErr_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            commitPend_r <= 1'b0;
            framingErr_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    bitCnt_r <= '0;
                    if (!rxS_r) begin
                        state_r <= START;
                        busy_r  <= 1'b1;
                    end
                end
                START: begin
                    if (rxS_r) begin
                        state_r  <= IDLE;
                        bitCnt_r <= '0;
                        busy_r   <= 1'b0;
                    end else if (bitCnt_r == HALF_LAST) begin
                        state_r  <= DATA;
                        bitCnt_r <= '0;
                        bitIdx_r <= 3'd0;
                    end else begin
                        bitCnt_r <= bitCnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (bitCnt_r == BIT_LAST) begin
                        shiftReg_r <= {rxS_r, shiftReg_r[7:1]};
                        bitCnt_r   <= '0;
                        if (bitIdx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            bitIdx_r <= bitIdx_r + 3'd1;
                        end
                    end else begin
                        bitCnt_r <= bitCnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    if (bitCnt_r == BIT_LAST) begin
                        bitCnt_r <= '0;
                        if (rxS_r) begin
                            commitPend_r <= 1'b1;
                            state_r      <= IDLE;
                            busy_r       <= 1'b0;
                        end else begin
                            framingErr_r <= 1'b1;
                            state_r      <= WAIT_HIGH;
                        end
                    end else begin
                        bitCnt_r <= bitCnt_r + CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    bitCnt_r <= '0;
                    if (rxS_r) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    bitCnt_r <= '0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    // Holding register: a commit always wins over a same-edge consume.
    always_ff @(posedge sclk) begin
        if (!rstn) begin
            outByte_r   <= 8'h00;
            dataValid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            if (commitPend_r) begin
                outByte_r   <= shiftReg_r;
                dataValid_r <= 1'b1;
                overrun_r   <= dataValid_r & ~dataReady;
            end else if (dataValid_r && dataReady) begin
                dataValid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of frames streamed back to back plus
// hand-written sequences for latency, glitch, break, overrun and reset corners.
module tb_uart_receiver;

    localparam int CLKFREQ_TB = 50_000_000;
    localparam int BAUD_TB    = 115200;
    localparam int CPB        = CLKFREQ_TB / BAUD_TB;
    localparam int HALF       = CPB / 2;
    localparam int CPB_FAST   = CPB * 98 / 100;
    localparam int CPB_SLOW   = CPB * 102 / 100;
    localparam int LATENCY    = 2 + HALF + 9 * CPB + 1;

    logic       sclk      = 1'b0;
    logic       rstn      = 1'b0;
    logic       uartRx    = 1'b1;
    logic       dataReady = 1'b0;
    logic [7:0] outByte;
    logic       dataValid;
    logic       framingErr;
    logic       overrun;
    logic       busy;

    always #5 sclk = ~sclk;

    uart_receiver #(
        .CLKFREQ (CLKFREQ_TB),
        .BAUDRATE(BAUD_TB)
    ) dut (
        .sclk      (sclk),
        .rstn      (rstn),
        .uartRx    (uartRx),
        .outByte   (outByte),
        .dataValid (dataValid),
        .dataReady (dataReady),
        .framingErr(framingErr),
        .overrun   (overrun),
        .busy      (busy)
    );

    int         cycleCnt      = 0;
    int         nRise         = 0;
    int         nValidHi      = 0;
    int         nFerr         = 0;
    int         nOvr          = 0;
    int         nBusy         = 0;
    int         lastRiseCycle = 0;
    logic       prevValid     = 1'b0;
    logic [7:0] captured[$];

    int checks = 0;
    int errors = 0;

    always @(posedge sclk) cycleCnt <= cycleCnt + 1;

    always @(negedge sclk) begin
        if (dataValid) nValidHi <= nValidHi + 1;
        if (framingErr) nFerr <= nFerr + 1;
        if (overrun) nOvr <= nOvr + 1;
        if (busy) nBusy <= nBusy + 1;
        if (dataValid && !prevValid) begin
            nRise         <= nRise + 1;
            lastRiseCycle <= cycleCnt;
            captured.push_back(outByte);
        end
        prevValid <= dataValid;
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic sendBit(input logic v, input int cycles);
        uartRx = v;
        repeat (cycles) @(posedge sclk);
        #1;
    endtask

    task automatic sendFrame(input logic [7:0] d, input int cpb, input logic stopBit);
        sendBit(1'b0, cpb);
        for (int i = 0; i < 8; i++) sendBit(d[i], cpb);
        sendBit(stopBit, cpb);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge sclk);
        #1;
    endtask

    function automatic int lastByte();
        if (captured.size() == 0) return -1;
        return int'(captured[captured.size()-1]);
    endfunction

    typedef struct {
        logic [7:0] data;
        int         cpb;
        int         expByte;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int r0, f0, o0, v0, b0, t0, n;
        logic timedOut;
        logic [7:0] partial;

        vecs[0] = '{8'h00, CPB,      32'h00};
        vecs[1] = '{8'hFF, CPB,      32'hFF};
        vecs[2] = '{8'h55, CPB,      32'h55};
        vecs[3] = '{8'h00, CPB_FAST, 32'h00};
        vecs[4] = '{8'hFF, CPB_FAST, 32'hFF};
        vecs[5] = '{8'h55, CPB_FAST, 32'h55};
        vecs[6] = '{8'h00, CPB_SLOW, 32'h00};
        vecs[7] = '{8'hFF, CPB_SLOW, 32'hFF};
        vecs[8] = '{8'h55, CPB_SLOW, 32'h55};

        // reset state
        rstn = 1'b0;
        idle(4);
        check("rst_outByte", int'(outByte), 0);
        check("rst_dataValid", int'(dataValid), 0);
        check("rst_framingErr", int'(framingErr), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_busy", int'(busy), 0);
        rstn = 1'b1;
        idle(10);

        // single byte, latency, one-cycle consume
        dataReady = 1'b0;
        f0 = nFerr; o0 = nOvr;
        t0 = cycleCnt;
        sendFrame(8'hA5, CPB, 1'b1);
        idle(20);
        checkRange("single_latency", lastRiseCycle - t0, LATENCY - 2, LATENCY + 2);
        check("single_outByte", int'(outByte), 32'hA5);
        check("single_dataValid", int'(dataValid), 1);
        check("single_ferr", nFerr - f0, 0);
        check("single_ovr", nOvr - o0, 0);
        dataReady = 1'b1;
        idle(1);
        dataReady = 1'b0;
        check("consume_dataValid", int'(dataValid), 0);
        check("consume_holdByte", int'(outByte), 32'hA5);

        // back-to-back table at nominal and +/-2% bit periods, ready held high
        dataReady = 1'b1;
        v0 = nValidHi;
        for (int i = 0; i < 9; i++) begin
            r0 = nRise; f0 = nFerr; o0 = nOvr;
            sendFrame(vecs[i].data, vecs[i].cpb, 1'b1);
            check($sformatf("b2b%0d_rise", i), nRise - r0, 1);
            check($sformatf("b2b%0d_byte", i), lastByte(), vecs[i].expByte);
            check($sformatf("b2b%0d_ferr", i), nFerr - f0, 0);
            check($sformatf("b2b%0d_ovr", i), nOvr - o0, 0);
        end
        idle(10);
        check("b2b_validCycles", nValidHi - v0, 9);
        check("b2b_validLow", int'(dataValid), 0);

        // start-bit glitch
        b0 = nBusy; r0 = nRise; f0 = nFerr; o0 = nOvr;
        sendBit(1'b0, 200);
        uartRx = 1'b1;
        idle(600);
        checkRange("glitch_busyCycles", nBusy - b0, 190, 205);
        check("glitch_busyEnd", int'(busy), 0);
        check("glitch_rise", nRise - r0, 0);
        check("glitch_ferr", nFerr - f0, 0);
        check("glitch_ovr", nOvr - o0, 0);

        // framing error followed by a break, then a good frame
        r0 = nRise; f0 = nFerr; o0 = nOvr;
        sendFrame(8'h3C, CPB, 1'b0);
        sendBit(1'b0, 3 * CPB);
        check("break_ferr", nFerr - f0, 1);
        check("break_busy", int'(busy), 1);
        sendBit(1'b1, CPB);
        check("break_noFrame", nRise - r0, 0);
        sendFrame(8'h81, CPB, 1'b1);
        idle(20);
        check("break_rise", nRise - r0, 1);
        check("break_byte", lastByte(), 32'h81);
        check("break_ferrTotal", nFerr - f0, 1);
        check("break_ovr", nOvr - o0, 0);

        // overrun with ready low
        dataReady = 1'b0;
        o0 = nOvr;
        sendFrame(8'h11, CPB, 1'b1);
        sendFrame(8'h22, CPB, 1'b1);
        idle(20);
        check("ovr_pulses", nOvr - o0, 1);
        check("ovr_outByte", int'(outByte), 32'h22);
        check("ovr_dataValid", int'(dataValid), 1);

        // ready exactly on the commit edge: consume old, load new, no overrun
        o0 = nOvr;
        timedOut = 1'b0;
        fork
            sendFrame(8'h33, CPB, 1'b1);
            begin
                n = 0;
                while (!busy && n < 2000) begin
                    @(negedge sclk);
                    n++;
                end
                while (busy && n < 10000) begin
                    @(negedge sclk);
                    n++;
                end
                if (n >= 10000 || !(n > 0)) begin
                    timedOut = 1'b1;
                end else begin
                    dataReady = 1'b1;
                    @(posedge sclk);
                    #1;
                    dataReady = 1'b0;
                end
            end
        join
        idle(20);
        check("ovrReady_wait", int'(timedOut), 0);
        check("ovrReady_pulses", nOvr - o0, 0);
        check("ovrReady_outByte", int'(outByte), 32'h33);
        check("ovrReady_dataValid", int'(dataValid), 1);

        // reset in the middle of data bit 4 of 0xF0, with a byte still held
        partial = 8'hF0;
        r0 = nRise;
        sendBit(1'b0, CPB);
        for (int i = 0; i < 4; i++) sendBit(partial[i], CPB);
        uartRx = partial[4];
        idle(CPB / 2);
        rstn = 1'b0;
        idle(1);
        rstn = 1'b1;
        check("midRst_dataValid", int'(dataValid), 0);
        check("midRst_outByte", int'(outByte), 0);
        check("midRst_busy", int'(busy), 0);
        check("midRst_ferr", int'(framingErr), 0);
        check("midRst_ovr", int'(overrun), 0);
        sendBit(1'b1, CPB - CPB / 2 - 1 + 4 * CPB);
        idle(CPB);
        check("midRst_noFrame", nRise - r0, 0);
        check("midRst_idle", int'(busy), 0);
        sendFrame(8'h96, CPB, 1'b1);
        idle(20);
        check("afterRst_rise", nRise - r0, 1);
        check("afterRst_outByte", int'(outByte), 32'h96);
        check("afterRst_dataValid", int'(dataValid), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
